// File: rtl/mem_addr_decoder_ws.sv
// Registered data-memory bank decoder with per-access wait states and a req/ack handshake.
// Out-of-range addresses take a one-cycle FAULT path that pulses ACK and ERR with no bank selected.
module mem_addr_decoder_ws #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned NUM_SEL = 16,
   parameter int unsigned WAIT_W  = 3
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               REQ,
   input  logic               WE,
   input  logic [ADDR_W-1:0]  ADDR,
   input  logic [WAIT_W-1:0]  WAIT_CYC,
   output logic [NUM_SEL-1:0] SEL,
   output logic               SEL_WE,
   output logic               ACK,
   output logic               ERR,
   output logic               BUSY
);

   localparam int unsigned NUM_ADDR = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_FAULT  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [WAIT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_SEL-1:0]  sel_q, sel_d;
   logic                sel_we_q, sel_we_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic [NUM_SEL-1:0]  hot_c;
   logic                in_range_c;

   // With every address populated the range check folds away entirely.
   if (NUM_SEL >= NUM_ADDR) begin : g_full
      assign in_range_c = 1'b1;
   end else begin : g_part
      assign in_range_c = (ADDR < ADDR_W'(NUM_SEL));
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         we_q     <= 1'b0;
         cnt_q    <= '0;
         sel_q    <= '0;
         sel_we_q <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         sel_we_q <= sel_we_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (REQ) begin
               if (in_range_c) begin
                  state_d = ST_ACCESS;
                  addr_d  = ADDR;
                  we_d    = WE;
                  cnt_d   = WAIT_CYC;
               end else begin
                  state_d = ST_FAULT;
               end
            end
         end
         ST_ACCESS: begin
            // Only decrement while non-zero so the counter can never wrap.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - WAIT_W'(1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FAULT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      for (int unsigned i = 0; i < NUM_SEL; i++) begin
         hot_c[i] = (addr_d == ADDR_W'(i));
      end

      // Outputs are registered from the next state so they line up with it.
      sel_d    = (state_d == ST_ACCESS) ? hot_c : '0;
      sel_we_d = (state_d == ST_ACCESS) && we_d;
      ack_d    = ((state_d == ST_ACCESS) && (cnt_d == '0)) || (state_d == ST_FAULT);
      err_d    = (state_d == ST_FAULT);
      busy_d   = (state_d != ST_IDLE);
   end

   assign SEL    = sel_q;
   assign SEL_WE = sel_we_q;
   assign ACK    = ack_q;
   assign ERR    = err_q;
   assign BUSY   = busy_q;

endmodule

// File: tb/tb_mem_addr_decoder_ws.sv
// Scoreboard bench: a default-config DUT and a NUM_SEL=12 DUT share stimulus;
// expected transactions are queued at issue time and checked by a monitor on each ACK.
module tb_mem_addr_decoder_ws;

   typedef struct packed {
      logic [15:0] sel;
      logic        we;
      logic        err;
      logic [4:0]  len;
   } exp_t;

   logic        CLK;
   logic        RST_N;
   logic        REQ;
   logic        WE;
   logic [3:0]  ADDR;
   logic [2:0]  WAIT_CYC;

   logic [15:0] sel_a;
   logic        sel_we_a, ack_a, err_a, busy_a;
   logic [11:0] sel_b;
   logic        sel_we_b, ack_b, err_b, busy_b;

   int          n_tests = 0;
   int          n_fail  = 0;

   exp_t        qa[$];
   exp_t        qb[$];
   int          run_len [2];
   logic [15:0] run_sel [2];
   logic        run_we  [2];

   mem_addr_decoder_ws u_dut_a (
      .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WAIT_CYC(WAIT_CYC),
      .SEL(sel_a), .SEL_WE(sel_we_a), .ACK(ack_a), .ERR(err_a), .BUSY(busy_a)
   );

   mem_addr_decoder_ws #(.ADDR_W(4), .NUM_SEL(12), .WAIT_W(3)) u_dut_b (
      .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WAIT_CYC(WAIT_CYC),
      .SEL(sel_b), .SEL_WE(sel_we_b), .ACK(ack_b), .ERR(err_b), .BUSY(busy_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Per-DUT monitor step: invariants every cycle, full transaction compare on ACK.
   function automatic void mon_step(int id, logic [15:0] sel, logic we, logic ack,
                                    logic err, logic busy);
      string pfx = (id == 0) ? "a_" : "b_";
      exp_t  e;
      if (!busy) begin
         chk({pfx, "idle_outputs"}, 32'({sel, we, ack, err}), 32'd0);
         run_len[id] = 0;
         return;
      end
      chk({pfx, "onehot"}, 32'($countones(sel) > 1), 32'd0);
      if (run_len[id] == 0) begin
         run_sel[id] = sel;
         run_we[id]  = we;
      end else begin
         chk({pfx, "sel_stable"}, 32'({sel, we}), 32'({run_sel[id], run_we[id]}));
      end
      run_len[id]++;
      if (!ack) begin
         chk({pfx, "err_without_ack"}, 32'(err), 32'd0);
         return;
      end
      if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
         chk({pfx, "unexpected_ack"}, 32'd1, 32'd0);
      end else begin
         e = (id == 0) ? qa.pop_front() : qb.pop_front();
         chk({pfx, "sel"},    32'(sel), 32'(e.sel));
         chk({pfx, "sel_we"}, 32'(we),  32'(e.we));
         chk({pfx, "err"},    32'(err), 32'(e.err));
         chk({pfx, "len"},    32'(run_len[id]), 32'(e.len));
      end
      run_len[id] = 0;
   endfunction

   always @(negedge CLK) begin
      mon_step(0, sel_a, sel_we_a, ack_a, err_a, busy_a);
      mon_step(1, 16'(sel_b), sel_we_b, ack_b, err_b, busy_b);
   end

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(negedge CLK);
         if (!busy_a && !busy_b) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   // Issue one request; optionally scramble the inputs right after acceptance.
   task automatic send(input logic [3:0] a, input logic w, input logic [2:0] wt,
                       input exp_t ea, input exp_t eb, input bit scramble);
      @(negedge CLK);
      REQ = 1'b1; ADDR = a; WE = w; WAIT_CYC = wt;
      qa.push_back(ea);
      qb.push_back(eb);
      @(posedge CLK);
      #1;
      REQ = 1'b0;
      chk("accept_latency_a", 32'(busy_a), 32'd1);
      chk("accept_latency_b", 32'(busy_b), 32'd1);
      if (scramble) begin
         ADDR = 4'h0; WE = ~w; WAIT_CYC = 3'd0;
      end
      wait_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t ea, eb;
      run_len[0] = 0; run_len[1] = 0;
      RST_N = 1'b0; REQ = 1'b0; WE = 1'b0; ADDR = 4'h0; WAIT_CYC = 3'd0;
      #1;
      chk("reset_state_a", 32'({sel_a, sel_we_a, ack_a, err_a, busy_a}), 32'd0);
      chk("reset_state_b", 32'({sel_b, sel_we_b, ack_b, err_b, busy_b}), 32'd0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;

      // Reset mid-access: abort in the second ACCESS cycle, nothing queued.
      @(negedge CLK);
      REQ = 1'b1; ADDR = 4'd5; WAIT_CYC = 3'd4; WE = 1'b0;
      @(posedge CLK); #1; REQ = 1'b0;
      @(posedge CLK); #1;
      chk("mid_access_sel", 32'(sel_a), 32'h0020);
      RST_N = 1'b0;
      #1;
      chk("rst_abort_a", 32'({sel_a, ack_a, busy_a}), 32'd0);
      chk("rst_abort_b", 32'({sel_b, ack_b, busy_b}), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      // Zero-wait read immediately after reset release.
      send(4'd3, 1'b0, 3'd0, '{16'h0008, 1'b0, 1'b0, 5'd1}, '{16'h0008, 1'b0, 1'b0, 5'd1}, 1'b0);
      // Wait-state write, inputs changed mid-access; bank 15 is out of range for NUM_SEL=12.
      send(4'hF, 1'b1, 3'd3, '{16'h8000, 1'b1, 1'b0, 5'd4}, '{16'h0000, 1'b0, 1'b1, 5'd1}, 1'b1);
      // Out-of-range address 13 versus highest populated bank 11.
      send(4'd13, 1'b0, 3'd0, '{16'h2000, 1'b0, 1'b0, 5'd1}, '{16'h0000, 1'b0, 1'b1, 5'd1}, 1'b0);
      send(4'd11, 1'b1, 3'd0, '{16'h0800, 1'b1, 1'b0, 5'd1}, '{16'h0800, 1'b1, 1'b0, 5'd1}, 1'b0);

      // Held REQ: accepts at edges 0, 3 and 6, so exactly three accesses.
      @(negedge CLK);
      REQ = 1'b1; ADDR = 4'd1; WAIT_CYC = 3'd1; WE = 1'b0;
      for (int k = 0; k < 3; k++) begin
         qa.push_back('{16'h0002, 1'b0, 1'b0, 5'd2});
         qb.push_back('{16'h0002, 1'b0, 1'b0, 5'd2});
      end
      repeat (7) @(posedge CLK);
      #1;
      REQ = 1'b0;
      wait_idle();

      // Sweep every address at the maximum wait count.
      for (int a = 0; a < 16; a++) begin
         ea = '{16'(16'h0001 << a), a[0], 1'b0, 5'd8};
         eb = (a < 12) ? ea : '{16'h0000, 1'b0, 1'b1, 5'd1};
         send(4'(a), a[0], 3'd7, ea, eb, 1'b0);
      end

      repeat (3) @(negedge CLK);
      chk("queue_a_drained", 32'(qa.size()), 32'd0);
      chk("queue_b_drained", 32'(qb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
